// File: rtl/gravsim_ball_frame_regs_if.sv
// Avalon-MM slave bus that carries NIOS register reads and writes into the ball frame registers.
// Reads have a fixed 1-cycle latency; there is no waitrequest and no backpressure.
interface gravsim_ball_frame_regs_if #(
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] avs_address;
   logic              avs_write;
   logic [31:0]       avs_writedata;
   logic [3:0]        avs_byteenable;
   logic              avs_read;
   logic [31:0]       avs_readdata;

   modport master (output avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
                   input  avs_readdata);
   modport slave  (input  avs_address, avs_write, avs_writedata, avs_byteenable, avs_read,
                   output avs_readdata);
endinterface

// File: rtl/gravsim_ball_frame_regs.sv
// Shadow/active ball register banks; the shadow is swapped into active on the VGA_VS fall, and a circle hit test is registered 1 cycle.
// Reads: 1-cycle latency, no waitrequest. Define GRAVSIM_BALL_ID_EN to add the ball_id output.
module gravsim_ball_frame_regs #(
   parameter int NUM_BALLS = 4,
   parameter int RADIUS_W  = 6,
   parameter int ADDR_W    = 4
`ifdef GRAVSIM_BALL_ID_EN
   ,
   localparam int ID_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1
`endif
) (
   input  logic                     Clk,
   input  logic                     Reset,
   gravsim_ball_frame_regs_if.slave avs,
   input  logic                     VGA_VS,
   input  logic [9:0]               DrawX,
   input  logic [9:0]               DrawY,
   output logic                     is_ball,
`ifdef GRAVSIM_BALL_ID_EN
   output logic [ID_W-1:0]          ball_id,
`endif
   output logic [15:0]              frame_count
);
   localparam logic [31:0] CTRL_A = 32'(2*NUM_BALLS);
   localparam logic [31:0] STAT_A = 32'(2*NUM_BALLS+1);

   logic [9:0]          sh_x_q  [NUM_BALLS], sh_x_d  [NUM_BALLS];
   logic [9:0]          sh_y_q  [NUM_BALLS], sh_y_d  [NUM_BALLS];
   logic [RADIUS_W-1:0] sh_r_q  [NUM_BALLS], sh_r_d  [NUM_BALLS];
   logic                sh_en_q [NUM_BALLS], sh_en_d [NUM_BALLS];
   logic [9:0]          act_x_q [NUM_BALLS], act_x_d [NUM_BALLS];
   logic [9:0]          act_y_q [NUM_BALLS], act_y_d [NUM_BALLS];
   logic [RADIUS_W-1:0] act_r_q [NUM_BALLS], act_r_d [NUM_BALLS];
   logic                act_en_q[NUM_BALLS], act_en_d[NUM_BALLS];

   logic                commit_pend_q, commit_pend_d;
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                vs_s1_q, vs_s2_q, vs_s3_q;
   logic                is_ball_q;
   logic                vs_fall;
   logic [ADDR_W-1:0]   addr;
   logic [31:0]         wa, wd, be_mask;
   logic [NUM_BALLS-1:0] hit;

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [31:0] mask);
      return (old_w & ~mask) | (new_w & mask);
   endfunction

   assign addr    = avs.avs_address;
   assign vs_fall = vs_s3_q & ~vs_s2_q;

   always_comb begin
      wa            = 32'(addr);
      wd            = avs.avs_writedata;
      be_mask       = {{8{avs.avs_byteenable[3]}}, {8{avs.avs_byteenable[2]}},
                       {8{avs.avs_byteenable[1]}}, {8{avs.avs_byteenable[0]}}};
      sh_x_d        = sh_x_q;
      sh_y_d        = sh_y_q;
      sh_r_d        = sh_r_q;
      sh_en_d       = sh_en_q;
      act_x_d       = act_x_q;
      act_y_d       = act_y_q;
      act_r_d       = act_r_q;
      act_en_d      = act_en_q;
      commit_pend_d = commit_pend_q;
      frame_cnt_d   = frame_cnt_q;
      rdata_d       = rdata_q;

      // The commit copies the pre-write shadow; a write in the same cycle lands in the shadow only.
      if (vs_fall && commit_pend_q) begin
         act_x_d       = sh_x_q;
         act_y_d       = sh_y_q;
         act_r_d       = sh_r_q;
         act_en_d      = sh_en_q;
         commit_pend_d = 1'b0;
         frame_cnt_d   = frame_cnt_q + 16'd1;
      end

      for (int k = 0; k < NUM_BALLS; k++) begin
         if (avs.avs_write && wa == 32'(2*k)) begin
            sh_x_d[k] = 10'(merge({6'd0, sh_y_q[k], 6'd0, sh_x_q[k]}, wd, be_mask));
            sh_y_d[k] = 10'(merge({6'd0, sh_y_q[k], 6'd0, sh_x_q[k]}, wd, be_mask) >> 16);
         end
         if (avs.avs_write && wa == 32'(2*k+1)) begin
            sh_r_d[k]  = RADIUS_W'(merge({sh_en_q[k], 31'(sh_r_q[k])}, wd, be_mask));
            sh_en_d[k] = 1'(merge({sh_en_q[k], 31'(sh_r_q[k])}, wd, be_mask) >> 31);
         end
      end
      if (avs.avs_write && wa == CTRL_A && avs.avs_byteenable[0] && wd[0])
         commit_pend_d = 1'b1;

      if (avs.avs_read) begin
         rdata_d = '0;
         for (int k = 0; k < NUM_BALLS; k++) begin
            if (wa == 32'(2*k))   rdata_d = {6'd0, sh_y_q[k], 6'd0, sh_x_q[k]};
            if (wa == 32'(2*k+1)) rdata_d = {sh_en_q[k], 31'(sh_r_q[k])};
         end
         if (wa == STAT_A) rdata_d = {commit_pend_q, 15'd0, frame_cnt_q};
      end
   end

   for (genvar k = 0; k < NUM_BALLS; k++) begin : g_hit
      logic signed [10:0] dx, dy;
      logic signed [21:0] dx2, dy2;
      logic        [21:0] r2;
      assign dx     = $signed({1'b0, DrawX}) - $signed({1'b0, act_x_q[k]});
      assign dy     = $signed({1'b0, DrawY}) - $signed({1'b0, act_y_q[k]});
      assign dx2    = 22'(dx) * 22'(dx);
      assign dy2    = 22'(dy) * 22'(dy);
      assign r2     = 22'(act_r_q[k]) * 22'(act_r_q[k]);
      assign hit[k] = act_en_q[k] && (($unsigned(dx2) + $unsigned(dy2)) <= r2);
   end

`ifdef GRAVSIM_BALL_ID_EN
   logic [ID_W-1:0] ball_id_q, ball_id_d;

   always_comb begin
      ball_id_d = '0;
      for (int k = NUM_BALLS-1; k >= 0; k--)
         if (hit[k]) ball_id_d = ID_W'(k);
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) ball_id_q <= '0;
      else       ball_id_q <= ball_id_d;
   end

   assign ball_id = ball_id_q;
`endif

   // Synchronizer flops reset high so that releasing reset never looks like a VS fall.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sh_x_q        <= '{default: '0};
         sh_y_q        <= '{default: '0};
         sh_r_q        <= '{default: '0};
         sh_en_q       <= '{default: 1'b0};
         act_x_q       <= '{default: '0};
         act_y_q       <= '{default: '0};
         act_r_q       <= '{default: '0};
         act_en_q      <= '{default: 1'b0};
         commit_pend_q <= 1'b0;
         frame_cnt_q   <= '0;
         rdata_q       <= '0;
         is_ball_q     <= 1'b0;
         vs_s1_q       <= 1'b1;
         vs_s2_q       <= 1'b1;
         vs_s3_q       <= 1'b1;
      end else begin
         sh_x_q        <= sh_x_d;
         sh_y_q        <= sh_y_d;
         sh_r_q        <= sh_r_d;
         sh_en_q       <= sh_en_d;
         act_x_q       <= act_x_d;
         act_y_q       <= act_y_d;
         act_r_q       <= act_r_d;
         act_en_q      <= act_en_d;
         commit_pend_q <= commit_pend_d;
         frame_cnt_q   <= frame_cnt_d;
         rdata_q       <= rdata_d;
         is_ball_q     <= |hit;
         vs_s1_q       <= VGA_VS;
         vs_s2_q       <= vs_s1_q;
         vs_s3_q       <= vs_s2_q;
      end
   end

   assign avs.avs_readdata = rdata_q;
   assign is_ball          = is_ball_q;
   assign frame_count      = frame_cnt_q;
endmodule

// File: tb/tb_gravsim_ball_frame_regs.sv
// Randomized bench for gravsim_ball_frame_regs; a register-word model predicts readdata, is_ball, frame_count and ball_id.
module tb_gravsim_ball_frame_regs;
   localparam int N = 4;
   localparam int RW = 6;
   localparam logic [31:0] POS_M = 32'h03FF_03FF;
   localparam logic [31:0] CFG_M = 32'h8000_003F;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        VGA_VS = 1'b1;
   logic [9:0]  DrawX = '0;
   logic [9:0]  DrawY = '0;
   logic        is_ball;
   logic [15:0] frame_count;
`ifdef GRAVSIM_BALL_ID_EN
   logic [1:0]  ball_id;
`endif

   gravsim_ball_frame_regs_if #(.ADDR_W(4)) bus ();

   gravsim_ball_frame_regs #(.NUM_BALLS(N), .RADIUS_W(RW), .ADDR_W(4)) dut (
      .Clk(Clk), .Reset(Reset), .avs(bus), .VGA_VS(VGA_VS), .DrawX(DrawX), .DrawY(DrawY),
      .is_ball(is_ball),
`ifdef GRAVSIM_BALL_ID_EN
      .ball_id(ball_id),
`endif
      .frame_count(frame_count));

   always #5 Clk = ~Clk;

   // Model state: register words as software sees them.
   logic [31:0] sh_pos[N], sh_cfg[N], act_pos[N], act_cfg[N];
   logic        m_pend;
   logic [15:0] m_fc;
   logic [31:0] m_rd;
   logic        m_ball;
   int          m_id;
   int          cyc = 0;
   logic        vs_prev;
   int          vsq[$];

   function automatic logic [31:0] m_read(input int a);
      if (a < 2*N) return (a % 2 == 0) ? sh_pos[a/2] : sh_cfg[a/2];
      if (a == 2*N+1) return {m_pend, 15'd0, m_fc};
      return 32'd0;
   endfunction

   function automatic int m_hit_id(input int px, input int py);
      for (int k = 0; k < N; k++) begin
         int x, y, r;
         x = int'(act_pos[k][9:0]);
         y = int'(act_pos[k][25:16]);
         r = int'(act_cfg[k][RW-1:0]);
         if (act_cfg[k][31] && (px-x)*(px-x) + (py-y)*(py-y) <= r*r) return k;
      end
      return -1;
   endfunction

   // A raw VS fall sampled at edge j becomes a commit opportunity at edge j+2.
   always @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int k = 0; k < N; k++) begin
            sh_pos[k] = 0; sh_cfg[k] = 0; act_pos[k] = 0; act_cfg[k] = 0;
         end
         m_pend = 0; m_fc = 0; m_rd = 0; m_ball = 0; m_id = 0;
         vs_prev = 1; vsq.delete();
      end else begin : mstep
         int hid, a;
         bit fall;
         logic [31:0] bm, wd;
         cyc++;
         fall = (vsq.size() > 0) && (vsq[0] == cyc);
         if (fall) void'(vsq.pop_front());
         hid = m_hit_id(int'(DrawX), int'(DrawY));
         m_ball = (hid >= 0);
         m_id = (hid >= 0) ? hid : 0;
         a = int'(bus.avs_address);
         if (bus.avs_read) m_rd = m_read(a);
         if (fall && m_pend) begin
            act_pos = sh_pos; act_cfg = sh_cfg; m_pend = 0; m_fc = m_fc + 16'd1;
         end
         if (bus.avs_write) begin
            wd = bus.avs_writedata;
            bm = {{8{bus.avs_byteenable[3]}}, {8{bus.avs_byteenable[2]}},
                  {8{bus.avs_byteenable[1]}}, {8{bus.avs_byteenable[0]}}};
            if (a < 2*N) begin
               if (a % 2 == 0) sh_pos[a/2] = (sh_pos[a/2] & ~(bm & POS_M)) | (wd & bm & POS_M);
               else            sh_cfg[a/2] = (sh_cfg[a/2] & ~(bm & CFG_M)) | (wd & bm & CFG_M);
            end else if (a == 2*N && bus.avs_byteenable[0] && wd[0]) begin
               m_pend = 1;
            end
         end
         if (!VGA_VS && vs_prev) vsq.push_back(cyc + 2);
         vs_prev = VGA_VS;
      end
   end

   int checks = 0;
   int errors = 0;
   int vs_left = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge Clk);
      chk("readdata", bus.avs_readdata, m_rd);
      chk("is_ball", 32'(is_ball), 32'(m_ball));
      chk("frame_count", 32'(frame_count), 32'(m_fc));
`ifdef GRAVSIM_BALL_ID_EN
      chk("ball_id", 32'(ball_id), 32'(m_id));
`endif
      @(posedge Clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
      bus.avs_address = 4'(a); bus.avs_writedata = d; bus.avs_byteenable = be; bus.avs_write = 1'b1;
      tick();
      bus.avs_write = 1'b0;
   endtask

   task automatic rd_chk(input string name, input int a, input logic [31:0] exp);
      bus.avs_address = 4'(a); bus.avs_read = 1'b1;
      tick();
      bus.avs_read = 1'b0;
      chk(name, bus.avs_readdata, exp);
   endtask

   task automatic pix_chk(input string name, input int x, input int y, input logic exp);
      DrawX = 10'(x); DrawY = 10'(y);
      tick();
      chk(name, 32'(is_ball), 32'(exp));
   endtask

   task automatic vs_pulse();
      VGA_VS = 1'b0;
      repeat (3) tick();
      VGA_VS = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      bus.avs_address = '0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
      bus.avs_byteenable = '0; bus.avs_read = 1'b0;
      #1 Reset = 1'b1;
      repeat (3) tick();
      Reset = 1'b0;
      tick();

      rd_chk("status_after_reset", 2*N+1, 32'h0000_0000);
      pix_chk("reset_pix_centre", 320, 240, 1'b0);
      pix_chk("reset_pix_origin", 0, 0, 1'b0);

      wr(0, 32'h00F0_0140, 4'hF);
      wr(1, 32'h8000_0004, 4'hF);
      vs_pulse();
      pix_chk("no_ctrl_no_commit", 320, 240, 1'b0);
      chk("no_ctrl_fc", 32'(frame_count), 32'd0);

      wr(2*N, 32'h1, 4'hF);
      rd_chk("status_pending", 2*N+1, 32'h8000_0000);
      vs_pulse();
      pix_chk("hit_centre", 320, 240, 1'b1);
      pix_chk("hit_right_edge", 324, 240, 1'b1);
      pix_chk("hit_top_edge", 320, 236, 1'b1);
      pix_chk("miss_diagonal", 324, 244, 1'b0);
      pix_chk("miss_right", 325, 240, 1'b0);
      chk("fc_after_commit", 32'(frame_count), 32'd1);
      rd_chk("status_committed", 2*N+1, 32'h0000_0001);

      wr(0, 32'h0000_00FF, 4'b0001);
      rd_chk("pos0_byte0_write", 0, 32'h00F0_01FF);
      rd_chk("cfg0_read", 1, 32'h8000_0004);
      pix_chk("active_unchanged", 320, 240, 1'b1);
      pix_chk("shadow_not_live", 511, 240, 1'b0);

      // CTRL write lands in the same cycle as the synchronized VS fall.
      VGA_VS = 1'b0;
      tick();
      tick();
      wr(2*N, 32'h1, 4'hF);
      tick();
      VGA_VS = 1'b1;
      repeat (3) tick();
      rd_chk("status_deferred", 2*N+1, 32'h8000_0001);
      vs_pulse();
      rd_chk("status_deferred_commit", 2*N+1, 32'h0000_0002);
      pix_chk("moved_ball_live", 511, 240, 1'b1);
      pix_chk("old_position_gone", 320, 240, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         int sel, k, r, off;
         bus.avs_write = 1'b0;
         bus.avs_read = 1'b0;
         sel = int'($urandom_range(0, 9));
         if (sel < 3) begin
            bus.avs_address = (sel < 2) ? 4'($urandom_range(0, 2*N-1)) : 4'($urandom_range(2*N, 15));
            bus.avs_writedata = $urandom();
            bus.avs_byteenable = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            bus.avs_write = 1'b1;
         end else if (sel < 5) begin
            bus.avs_address = 4'($urandom_range(0, 15));
            bus.avs_read = 1'b1;
         end
         if (vs_left == 0) begin
            VGA_VS = ~VGA_VS;
            vs_left = VGA_VS ? int'($urandom_range(2, 30)) : int'($urandom_range(0, 5));
         end else begin
            vs_left--;
         end
         k = int'($urandom_range(0, N-1));
         r = int'(act_cfg[k][RW-1:0]);
         off = int'($urandom_range(0, 2*r+4)) - (r+2);
         DrawX = 10'(int'(act_pos[k][9:0]) + off);
         off = int'($urandom_range(0, 2*r+4)) - (r+2);
         DrawY = 10'(int'(act_pos[k][25:16]) + off);
         tick();
      end
      bus.avs_write = 1'b0;
      bus.avs_read = 1'b0;
      VGA_VS = 1'b1;
      repeat (4) tick();

      // Asynchronous reset in the middle of a frame with a ball live and a commit pending.
      wr(0, 32'h0064_0064, 4'hF);
      wr(1, 32'h8000_000A, 4'hF);
      wr(2*N, 32'h1, 4'hF);
      vs_pulse();
      pix_chk("pre_reset_hit", 100, 100, 1'b1);
      wr(2*N, 32'h1, 4'hF);
      VGA_VS = 1'b0;
      #3 Reset = 1'b1;
      #1;
      chk("reset_is_ball_now", 32'(is_ball), 32'd0);
      chk("reset_fc_now", 32'(frame_count), 32'd0);
      chk("reset_readdata_now", bus.avs_readdata, 32'd0);
      tick();
      tick();
      Reset = 1'b0;
      repeat (4) tick();
      chk("post_reset_no_commit", 32'(frame_count), 32'd0);
      pix_chk("post_reset_miss", 100, 100, 1'b0);
      vs_pulse();
      chk("post_reset_vs_no_commit", 32'(frame_count), 32'd0);
      rd_chk("post_reset_status", 2*N+1, 32'h0000_0000);
      rd_chk("post_reset_cfg0", 1, 32'h0000_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
